// File: rtl/osr_rx_sampler.sv
// Oversampling UART-style receiver: 2-flop synchronizer, start/data/stop framing, OSR clocks per bit.
// Latency: strobe 154 cycles after START entry at defaults ((1+DATA_BITS)*OSR + OSR/2 + 2).
// Backpressure: none; rx_valid/frame_err are single-cycle strobes. Optional OSR_RX_MAJORITY_EN selects 2-of-3 voting.
module osr_rx_sampler #(
    parameter int OSR       = 16,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CW = $clog2(OSR);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] CNT_MID  = CW'(OSR / 2);
    localparam logic [CW-1:0] CNT_DEC  = CW'(OSR / 2 + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OSR - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic [1:0]           sync_q;
    logic                 line_prev;
    logic                 line_s;
    logic                 samp_mid;
    logic                 bit_val;

    assign line_s = sync_q[1];
    assign busy   = (state != IDLE);

    // Synchronizer and previous-value flop; reset high so reset never looks like a falling edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= 2'b11;
            line_prev <= 1'b1;
        end else begin
            sync_q    <= {sync_q[0], rx_in};
            line_prev <= sync_q[1];
        end
    end

`ifdef OSR_RX_MAJORITY_EN
    localparam logic [CW-1:0] CNT_PRE = CW'(OSR / 2 - 1);
    logic samp_pre;

    // Capture the two samples ahead of the decision; the third is the live synced line at the decision count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            samp_pre <= 1'b1;
            samp_mid <= 1'b1;
        end else begin
            if (cnt == CNT_PRE) samp_pre <= line_s;
            if (cnt == CNT_MID) samp_mid <= line_s;
        end
    end

    assign bit_val = (samp_pre & samp_mid) | (samp_pre & line_s) | (samp_mid & line_s);
`else
    // Capture the single mid-bit sample used one cycle later at the decision count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            samp_mid <= 1'b1;
        end else if (cnt == CNT_MID) begin
            samp_mid <= line_s;
        end
    end

    assign bit_val = samp_mid;
`endif

    // Framing FSM with registered strobes and word output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (state == IDLE) begin
                cnt <= '0;
            end else begin
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
            end
            case (state)
                IDLE: begin
                    bit_idx <= '0;
                    // A start needs a synced 1 followed by a 0, so a line stuck low cannot retrigger
                    if (line_prev && !line_s) begin
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == CNT_DEC && bit_val) begin
                        // Start bit not low at mid-bit: treat as a glitch and drop silently
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (cnt == CNT_DEC) begin
                        shreg <= (shreg >> 1) | (DATA_BITS'(bit_val) << (DATA_BITS - 1));
                    end
                    if (cnt == CNT_LAST) begin
                        if (bit_idx == BIT_LAST) begin
                            state   <= STOP;
                            bit_idx <= '0;
                        end else begin
                            bit_idx <= bit_idx + BW'(1);
                        end
                    end
                end
                STOP: begin
                    // Leave at mid-stop so a following start edge is caught even with a one-bit stop
                    if (cnt == CNT_DEC) begin
                        state <= IDLE;
                        cnt   <= '0;
                        if (bit_val) begin
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_osr_rx_sampler.sv
// Bench for osr_rx_sampler: directed scenarios plus randomized frames, scoreboard-checked.
// Expected words/strobe cycles are derived from the transmitted frame, not from DUT state.
// Monitor pops one expectation per rx_valid/frame_err strobe.
module tb_osr_rx_sampler;

    localparam int OSR = 16;
    localparam int DB  = 8;
    // Pin fall to strobe: 3 cycles to reach START, then (1+DB)*OSR + OSR/2 + 2
    localparam int LAT = (1 + DB) * OSR + OSR / 2 + 2 + 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rx_in = 1'b1;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          busy;

    osr_rx_sampler #(.OSR(OSR), .DATA_BITS(DB)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_in     (rx_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            err;
        logic [DB-1:0] data;
        int            cyc;
    } exp_t;

    exp_t          q[$];
    int            cyc = 0;
    int            n_pass = 0;
    int            n_total = 0;
    logic [DB-1:0] last_good = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input bit ok, input longint act, input longint req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic drive_cycle(input logic v);
        rx_in = v;
        @(posedge clk);
        #1;
    endtask

    // Send one frame; spike flips the pin for one cycle in the middle of each selected data bit
    task automatic send_frame(input logic [DB-1:0] d, input logic stop, input logic [DB-1:0] spike);
        exp_t          e;
        logic [DB-1:0] word;
        int            n;
        n = cyc;
`ifdef OSR_RX_MAJORITY_EN
        word = d;
`else
        word = d ^ spike;
`endif
        e.err  = !stop;
        e.data = stop ? word : last_good;
        e.cyc  = n + LAT;
        if (stop) last_good = word;
        q.push_back(e);
        for (int i = 0; i < OSR; i++) drive_cycle(1'b0);
        for (int b = 0; b < DB; b++)
            for (int i = 0; i < OSR; i++)
                drive_cycle((spike[b] && i == OSR / 2 + 1) ? ~d[b] : d[b]);
        for (int i = 0; i < OSR; i++) drive_cycle(stop);
    endtask

    // Monitor: every strobe must match the head of the scoreboard
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!reset) begin
            if (rx_valid && frame_err) check("both_strobes", 1'b0, 1, 0);
            if (rx_valid || frame_err) begin
                if (q.size() == 0) begin
                    check("unexpected_strobe", 1'b0, {rx_valid, frame_err}, 0);
                end else begin
                    e = q.pop_front();
                    check("strobe_kind", frame_err == e.err, frame_err, e.err);
                    check("rx_data", rx_data == e.data, rx_data, e.data);
                    check("strobe_cycle", cyc == e.cyc, cyc, e.cyc);
                    check("busy_at_strobe", busy == 1'b0, busy, 0);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int  n;
        bit  seen;
        bit  bad;
        logic [DB-1:0] d;
        logic          st;
        logic [DB-1:0] sp;
        int  gap;

        // Reset state
        #1;
        check("rst_rx_data", rx_data == '0, rx_data, 0);
        check("rst_rx_valid", rx_valid == 1'b0, rx_valid, 0);
        check("rst_frame_err", frame_err == 1'b0, frame_err, 0);
        check("rst_busy", busy == 1'b0, busy, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
        repeat (5) drive_cycle(1'b1);

        // Single good frame
        send_frame(8'hA5, 1'b1, 8'h00);
        repeat (10) drive_cycle(1'b1);

        // Back-to-back frames with one-bit stop: strobes 160 cycles apart
        send_frame(8'h00, 1'b1, 8'h00);
        send_frame(8'hFF, 1'b1, 8'h00);
        repeat (10) drive_cycle(1'b1);

        // Short low glitch: busy pulses, drops by START decision, no strobe
        n = cyc;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0);
            seen |= busy;
        end
        for (int i = 0; i < 9; i++) drive_cycle(1'b1);
        check("glitch_busy_seen", seen, seen, 1);
        check("glitch_busy_low", busy == 1'b0, busy, 0);
        check("glitch_cycle", cyc == n + 13, cyc, n + 13);
        check("glitch_rx_data", rx_data == last_good, rx_data, last_good);
        repeat (10) drive_cycle(1'b1);

        // Framing error, then line held low: no restart until it goes high
        send_frame(8'h3C, 1'b0, 8'h00);
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            drive_cycle(1'b0);
            bad |= busy;
        end
        check("held_low_no_busy", !bad, bad, 0);
        check("ferr_rx_data_kept", rx_data == last_good, rx_data, last_good);
        repeat (10) drive_cycle(1'b1);

        // Mid-bit spikes on every data bit
        send_frame(8'h5A, 1'b1, 8'hFF);
        repeat (10) drive_cycle(1'b1);

        // Reset in the middle of data bit 4
        for (int i = 0; i < OSR; i++) drive_cycle(1'b0);
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < OSR; i++) drive_cycle(b[0]);
        for (int i = 0; i < OSR / 2; i++) drive_cycle(1'b1);
        reset = 1'b1;
        #1;
        check("midrst_busy", busy == 1'b0, busy, 0);
        check("midrst_rx_data", rx_data == '0, rx_data, 0);
        check("midrst_rx_valid", rx_valid == 1'b0, rx_valid, 0);
        last_good = '0;
        rx_in = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
        repeat (5) drive_cycle(1'b1);
        check("postrst_busy", busy == 1'b0, busy, 0);
        send_frame(8'h81, 1'b1, 8'h00);
        repeat (5) drive_cycle(1'b1);

        // Randomized frames
        for (int k = 0; k < 16; k++) begin
            d   = DB'($urandom);
            st  = ($urandom_range(0, 4) != 0);
            sp  = ($urandom_range(0, 1) != 0) ? DB'($urandom) : '0;
            send_frame(d, st, sp);
            gap = $urandom_range(st ? 0 : 2, 6);
            for (int i = 0; i < gap; i++) drive_cycle(1'b1);
        end

        // Drain
        for (int i = 0; i < 300 && q.size() != 0; i++) drive_cycle(1'b1);
        check("scoreboard_empty", q.size() == 0, q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
